// File: rtl/bram_writer.sv
`default_nettype none
// ============================================================================
// Module   : bram_writer
// Brief    : Packs a byte stream little-endian into BRAM words and writes them
//            to sequential addresses on a BRAM port A.
//            Optional feature macro: BRAM_WRITER_PARTIAL_FLUSH_EN
// Revision : 1.0
// ============================================================================
module bram_writer #(
  parameter int ADDRESS_WIDTH  = 13,
  parameter int DATA_IN_WIDTH  = 8,
  parameter int DATA_OUT_WIDTH = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          en_i,
  input  logic [DATA_IN_WIDTH-1:0]      data_i,
  input  logic                          flush_i,
  input  logic                          clear_i,
  output logic                          ready_o,
  output logic                          full_o,
  output logic [ADDRESS_WIDTH:0]        word_count_o,
  output logic [ADDRESS_WIDTH-1:0]      bram_addr,
  output logic [DATA_OUT_WIDTH-1:0]     bram_data_o,
  output logic                          bram_en,
  output logic [DATA_OUT_WIDTH/8-1:0]   bram_we
);

  localparam int LANES  = DATA_OUT_WIDTH / 8;
  localparam int LANE_W = $clog2(LANES);
  localparam int CNT_W  = LANE_W + 1;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t                    r_state;
  state_t                    w_state_next;
  logic [LANE_W-1:0]         r_lane_cnt;
  logic [ADDRESS_WIDTH-1:0]  r_wr_ptr;
  logic [DATA_OUT_WIDTH-1:0] r_word;
  logic [DATA_OUT_WIDTH-1:0] w_word;
  logic [CNT_W-1:0]          w_filled;
  logic [LANES-1:0]          w_mask;
  logic                      w_accept;
  logic                      w_last;
  logic                      w_flush;
  logic                      w_write;

  // Clear wins over everything: the byte presented with it is dropped.
  assign w_accept = en_i && ready_o && !clear_i;
  assign w_last   = w_accept && (r_lane_cnt == LANE_W'(LANES - 1));
  assign w_filled = {1'b0, r_lane_cnt} + CNT_W'(w_accept);

`ifdef BRAM_WRITER_PARTIAL_FLUSH_EN
  // A byte arriving with flush is packed first; a completed word needs no flush.
  assign w_flush = flush_i && ready_o && !clear_i && !w_last &&
                   (w_filled != '0);
`else
  logic w_unused_flush;
  assign w_unused_flush = flush_i;
  assign w_flush        = 1'b0;
`endif

  assign w_write = w_last || w_flush;

  always_comb begin
    w_word = r_word;
    w_mask = '0;
    for (int i = 0; i < LANES; i++) begin
      if (w_accept && (LANE_W'(i) == r_lane_cnt)) begin
        w_word[i*8 +: 8] = data_i[7:0];
      end
      w_mask[i] = (CNT_W'(i) < w_filled);
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      FILL: begin
        if (!clear_i && w_write && (r_wr_ptr == '1)) begin
          w_state_next = FULL;
        end
      end
      FULL: begin
        if (clear_i) begin
          w_state_next = FILL;
        end
      end
      default: w_state_next = FILL;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= FILL;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ready_o      <= 1'b0;
      full_o       <= 1'b0;
      word_count_o <= '0;
      bram_addr    <= '0;
      bram_data_o  <= '0;
      bram_en      <= 1'b0;
      bram_we      <= '0;
      r_lane_cnt   <= '0;
      r_wr_ptr     <= '0;
      r_word       <= '0;
    end else begin
      ready_o <= (w_state_next == FILL);
      full_o  <= (w_state_next == FULL);
      bram_en <= w_write;
      bram_we <= w_write ? w_mask : '0;
      if (clear_i) begin
        r_wr_ptr     <= '0;
        word_count_o <= '0;
        r_lane_cnt   <= '0;
        r_word       <= '0;
      end else if (w_write) begin
        bram_addr    <= r_wr_ptr;
        bram_data_o  <= w_word;
        r_wr_ptr     <= r_wr_ptr + ADDRESS_WIDTH'(1);
        word_count_o <= word_count_o + (ADDRESS_WIDTH + 1)'(1);
        r_lane_cnt   <= '0;
        // Zeroed so a later partial word carries 0 in its unfilled lanes.
        r_word       <= '0;
      end else if (w_accept) begin
        r_word     <= w_word;
        r_lane_cnt <= r_lane_cnt + LANE_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bram_writer.sv
`default_nettype none
// Testbench for bram_writer: directed scenarios plus random traffic checked
// against a queue-based byte/word reference model.
module tb_bram_writer;

  localparam int AW    = 3;
  localparam int DW    = 32;
  localparam int LANES = DW / 8;
  localparam int DEPTH = 1 << AW;
`ifdef BRAM_WRITER_PARTIAL_FLUSH_EN
  localparam bit FLUSH_ON = 1'b1;
`else
  localparam bit FLUSH_ON = 1'b0;
`endif

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             en_i;
  logic [7:0]       data_i;
  logic             flush_i;
  logic             clear_i;
  logic             ready_o;
  logic             full_o;
  logic [AW:0]      word_count_o;
  logic [AW-1:0]    bram_addr;
  logic [DW-1:0]    bram_data_o;
  logic             bram_en;
  logic [LANES-1:0] bram_we;

  bram_writer #(
    .ADDRESS_WIDTH (AW),
    .DATA_IN_WIDTH (8),
    .DATA_OUT_WIDTH(DW)
  ) u_dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .en_i        (en_i),
    .data_i      (data_i),
    .flush_i     (flush_i),
    .clear_i     (clear_i),
    .ready_o     (ready_o),
    .full_o      (full_o),
    .word_count_o(word_count_o),
    .bram_addr   (bram_addr),
    .bram_data_o (bram_data_o),
    .bram_en     (bram_en),
    .bram_we     (bram_we)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0]       m_bytes[$];
  int               m_ptr;
  int               m_cnt;
  bit               m_full;
  bit               m_ready;
  bit               m_en;
  logic [AW-1:0]    m_addr;
  logic [DW-1:0]    m_data;
  logic [LANES-1:0] m_we;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic emit();
    logic [DW-1:0] w;
    w = '0;
    foreach (m_bytes[i]) w[8*i +: 8] = m_bytes[i];
    m_data = w;
    m_we   = LANES'((1 << m_bytes.size()) - 1);
    m_addr = AW'(m_ptr);
    m_en   = 1'b1;
    m_ptr++;
    m_cnt++;
    if (m_ptr == DEPTH) m_full = 1'b1;
    m_bytes.delete();
  endtask

  task automatic model_edge(input bit en, input logic [7:0] d, input bit fl, input bit cl);
    bit wrote;
    wrote = 1'b0;
    m_en  = 1'b0;
    m_we  = '0;
    if (cl) begin
      m_bytes.delete();
      m_ptr  = 0;
      m_cnt  = 0;
      m_full = 1'b0;
    end else begin
      if (en && m_ready) begin
        m_bytes.push_back(d);
        if (m_bytes.size() == LANES) begin
          emit();
          wrote = 1'b1;
        end
      end
      if (FLUSH_ON && fl && m_ready && !wrote && m_bytes.size() > 0) emit();
    end
    m_ready = !m_full;
  endtask

  task automatic check_all();
    chk("ready_o", ready_o, m_ready);
    chk("full_o", full_o, m_full);
    chk("word_count_o", word_count_o, m_cnt);
    chk("bram_en", bram_en, m_en);
    chk("bram_we", bram_we, m_we);
    chk("bram_addr", bram_addr, m_addr);
    chk("bram_data_o", bram_data_o, m_data);
  endtask

  task automatic step(input bit en, input logic [7:0] d, input bit fl, input bit cl);
    en_i    = en;
    data_i  = d;
    flush_i = fl;
    clear_i = cl;
    @(posedge clk_i);
    model_edge(en, d, fl, cl);
    @(negedge clk_i);
    check_all();
  endtask

  task automatic do_reset();
    rst_i   = 1'b0;
    en_i    = 1'b0;
    flush_i = 1'b0;
    clear_i = 1'b0;
    data_i  = '0;
    #1;
    m_bytes.delete();
    m_ptr = 0; m_cnt = 0; m_full = 0; m_ready = 0; m_en = 0;
    m_we = '0; m_addr = '0; m_data = '0;
    check_all();
    @(negedge clk_i);
    rst_i = 1'b1;
    step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic expect_write(input string tag, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input logic [LANES-1:0] we);
    chk({tag, "_en"}, bram_en, 1'b1);
    chk({tag, "_addr"}, bram_addr, a);
    chk({tag, "_data"}, bram_data_o, d);
    chk({tag, "_we"}, bram_we, we);
  endtask

  initial begin
    rst_i = 1'b0; en_i = 1'b0; flush_i = 1'b0; clear_i = 1'b0; data_i = '0;
    @(negedge clk_i);

    // Test 1: back-to-back bytes 11..88
    do_reset();
    chk("t1_ready_after_reset", ready_o, 1'b1);
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 8'(8'h11 * (k + 1)), 1'b0, 1'b0);
      if (k == 3) expect_write("t1_w0", 3'd0, 32'h44332211, 4'hF);
      if (k == 7) expect_write("t1_w1", 3'd1, 32'h88776655, 4'hF);
    end
    chk("t1_count", word_count_o, 2);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("t1_en_drop", bram_en, 1'b0);
    chk("t1_addr_hold", bram_addr, 3'd1);

    // Test 3: AA BB CC then flush
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    step(1'b1, 8'hBB, 1'b0, 1'b0);
    step(1'b1, 8'hCC, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
`ifdef BRAM_WRITER_PARTIAL_FLUSH_EN
    expect_write("t3_flush", 3'd2, 32'h00CCBBAA, 4'h7);
    chk("t3_count", word_count_o, 3);
    step(1'b1, 8'hDD, 1'b0, 1'b0);
`else
    chk("t3_noflush", bram_en, 1'b0);
    step(1'b1, 8'hDD, 1'b0, 1'b0);
    expect_write("t3_word", 3'd2, 32'hDDCCBBAA, 4'hF);
`endif

    // Test 2: same bytes with random gaps
    do_reset();
    for (int k = 0; k < 8; k++) begin
      repeat ($urandom_range(0, 3)) step(1'b0, 8'($urandom), 1'b0, 1'b0);
      step(1'b1, 8'(8'h11 * (k + 1)), 1'b0, 1'b0);
    end
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("t2_count", word_count_o, 2);
    chk("t2_last_data", bram_data_o, 32'h88776655);

    // Test 4: fill all words, ignore bytes while full, clear restarts at 0
    do_reset();
    for (int k = 0; k < LANES * DEPTH; k++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    chk("t4_full", full_o, 1'b1);
    chk("t4_ready", ready_o, 1'b0);
    chk("t4_count", word_count_o, DEPTH);
    for (int k = 0; k < 6; k++) step(1'b1, 8'($urandom), 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("t4_full_cleared", full_o, 1'b0);
    for (int k = 1; k <= 4; k++) step(1'b1, 8'(k), 1'b0, 1'b0);
    expect_write("t4_after_clear", 3'd0, 32'h04030201, 4'hF);

    // Test 5: reset mid-word
    do_reset();
    step(1'b1, 8'hE1, 1'b0, 1'b0);
    step(1'b1, 8'hE2, 1'b0, 1'b0);
    do_reset();
    for (int k = 1; k <= 4; k++) step(1'b1, 8'(k), 1'b0, 1'b0);
    expect_write("t5_w0", 3'd0, 32'h04030201, 4'hF);

    // Test 6: clear with a same-cycle byte after 3 bytes
    do_reset();
    for (int k = 0; k < 3; k++) step(1'b1, 8'h90, 1'b0, 1'b0);
    step(1'b1, 8'h55, 1'b0, 1'b1);
    chk("t6_nowrite", bram_en, 1'b0);
    for (int k = 1; k <= 4; k++) step(1'b1, 8'(k), 1'b0, 1'b0);
    expect_write("t6_w0", 3'd0, 32'h04030201, 4'hF);

    // Flush together with the word-completing byte: ordinary full write
    for (int k = 0; k < 3; k++) step(1'b1, 8'h70, 1'b0, 1'b0);
    step(1'b1, 8'h71, 1'b1, 1'b0);
    expect_write("t7_en_flush", 3'd1, 32'h71707070, 4'hF);

    // Random traffic against the model
    do_reset();
    repeat (400) begin
      step(($urandom % 10) < 7, 8'($urandom), ($urandom % 10) == 0, ($urandom % 40) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
